// File: rtl/alu_issue_seq.sv
// Issue/sequencing stage in front of a 32-bit ALU: registers a command, drives one or two
// ALU passes (64-bit ops as low then high with carry chaining), and returns the result.
module alu_issue_seq #(
    parameter bit WIDE_EN   = 1'b1,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_f,
    input  logic [1:0]  cmd_dir,
    input  logic [4:0]  cmd_bite,
    input  logic        cmd_ci,
    input  logic        cmd_wide,
    input  logic [63:0] cmd_a,
    input  logic [63:0] cmd_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_ci,
    output logic [2:0]  alu_f,
    output logic [1:0]  alu_dir,
    output logic [4:0]  alu_bite,
    input  logic [31:0] alu_s,
    input  logic        alu_co,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_s,
    output logic        res_co,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] F_ADD   = 3'b001;
    localparam logic [2:0] F_SHIFT = 3'b010;
    localparam logic [2:0] F_TRUNC = 3'b011;

    logic [1:0]  state_q, state_d;
    logic        init_q;
    logic [2:0]  f_q, f_d;
    logic [1:0]  dir_q, dir_d;
    logic [4:0]  bite_q, bite_d;
    logic        ci_q, ci_d;
    logic        wide_q, wide_d;
    logic        carry_q, carry_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] res_s_q, res_s_d;
    logic        res_co_q, res_co_d;
    logic        hold_ci_q, hold_ci_d;

    logic        in_pass;
    logic        sel_hi;
    logic        accept;
    logic [31:0] drv_a;
    logic [31:0] drv_b;
    logic        drv_ci;

    assign cmd_ready = (state_q == ST_IDLE) && init_q;
    assign accept    = cmd_valid && cmd_ready;
    assign in_pass   = (state_q == ST_LO) || (state_q == ST_HI);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_s     = res_s_q;
    assign res_co    = res_co_q;

    // Outside the passes the operand registers still hold the last command, so the half that
    // was driven last is recovered from wide_q; only the carry-in needs its own hold register.
    assign sel_hi = (state_q == ST_HI) || (!in_pass && wide_q);

    always_comb begin
        drv_a  = sel_hi ? a_q[63:32] : a_q[31:0];
        drv_b  = sel_hi ? b_q[63:32] : b_q[31:0];
        drv_ci = hold_ci_q;
        if (state_q == ST_LO) begin
            drv_ci = ci_q;
        end else if (state_q == ST_HI) begin
            drv_ci = (f_q == F_ADD) && carry_q;
        end
    end

    always_comb begin
        alu_a    = drv_a;
        alu_b    = drv_b;
        alu_ci   = drv_ci;
        alu_f    = f_q;
        alu_dir  = dir_q;
        alu_bite = bite_q;
        if (ZERO_IDLE && !in_pass) begin
            alu_a    = '0;
            alu_b    = '0;
            alu_ci   = 1'b0;
            alu_f    = '0;
            alu_dir  = '0;
            alu_bite = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        dir_d     = dir_q;
        bite_d    = bite_q;
        ci_d      = ci_q;
        wide_d    = wide_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        res_s_d   = res_s_q;
        res_co_d  = res_co_q;
        hold_ci_d = hold_ci_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    f_d     = cmd_f;
                    dir_d   = cmd_dir;
                    bite_d  = cmd_bite;
                    ci_d    = cmd_ci;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    // Shift/truncate have no meaningful 64-bit form, so they stay single-pass.
                    wide_d  = cmd_wide && WIDE_EN && (cmd_f != F_SHIFT) && (cmd_f != F_TRUNC);
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                res_s_d[31:0] = alu_s;
                carry_d       = alu_co;
                hold_ci_d     = drv_ci;
                if (wide_q) begin
                    state_d = ST_HI;
                end else begin
                    res_s_d[63:32] = '0;
                    res_co_d       = (f_q == F_ADD) && alu_co;
                    state_d        = ST_DONE;
                end
            end
            ST_HI: begin
                res_s_d[63:32] = alu_s;
                carry_d        = alu_co;
                hold_ci_d      = drv_ci;
                res_co_d       = (f_q == F_ADD) && alu_co;
                state_d        = ST_DONE;
            end
            default: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            init_q    <= 1'b0;
            f_q       <= '0;
            dir_q     <= '0;
            bite_q    <= '0;
            ci_q      <= 1'b0;
            wide_q    <= 1'b0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_s_q   <= '0;
            res_co_q  <= 1'b0;
            hold_ci_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_q    <= 1'b1;
            f_q       <= f_d;
            dir_q     <= dir_d;
            bite_q    <= bite_d;
            ci_q      <= ci_d;
            wide_q    <= wide_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_s_q   <= res_s_d;
            res_co_q  <= res_co_d;
            hold_ci_q <= hold_ci_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural 32-bit ALU behind the stage, a transaction-level
// reference model checked every cycle, directed corner cases and randomized commands.
module tb_alu_issue_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_f;
    logic [1:0]  cmd_dir;
    logic [4:0]  cmd_bite;
    logic        cmd_ci;
    logic        cmd_wide;
    logic [63:0] cmd_a;
    logic [63:0] cmd_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_ci;
    logic [2:0]  alu_f;
    logic [1:0]  alu_dir;
    logic [4:0]  alu_bite;
    logic [31:0] alu_s;
    logic        alu_co;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_s;
    logic        res_co;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_seq #(.WIDE_EN(1'b1), .ZERO_IDLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_f(cmd_f), .cmd_dir(cmd_dir), .cmd_bite(cmd_bite), .cmd_ci(cmd_ci),
        .cmd_wide(cmd_wide), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_f(alu_f),
        .alu_dir(alu_dir), .alu_bite(alu_bite), .alu_s(alu_s), .alu_co(alu_co),
        .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_co(res_co),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in; CO for non-add ops is deliberately non-zero so the stage must mask it.
    function automatic logic [32:0] alu32(input logic [2:0] f, input logic [1:0] dir,
                                          input logic [4:0] bite, input logic [31:0] a,
                                          input logic [31:0] b, input logic ci);
        logic [31:0] s;
        logic [63:0] dbl;
        s   = '0;
        dbl = {a, a} << bite;
        case (f)
            3'd0: s = '0;
            3'd1: return {1'b0, a} + {1'b0, b} + {32'd0, ci};
            3'd2: case (dir)
                      2'd0: s = a << bite;
                      2'd1: s = a >> bite;
                      2'd2: s = $unsigned($signed(a) >>> bite);
                      default: s = dbl[63:32];
                  endcase
            3'd3: s = dir[0] ? (a & ~(32'hFFFF_FFFF >> bite)) : (a & ~(32'hFFFF_FFFF << bite));
            3'd4: s = a & b;
            3'd5: s = a | b;
            3'd6: s = ~a;
            default: s = a ^ b;
        endcase
        return {^a, s};
    endfunction

    always_comb {alu_co, alu_s} = alu32(alu_f, alu_dir, alu_bite, alu_a, alu_b, alu_ci);

    // Expected {co, s} of a whole command, computed as one 64-bit (or 32-bit) operation.
    function automatic logic [64:0] ref_result(input logic [2:0] f, input logic [1:0] dir,
                                               input logic [4:0] bite, input logic ci,
                                               input logic wide, input logic [63:0] a,
                                               input logic [63:0] b);
        logic        weff;
        logic [63:0] s;
        logic [32:0] n;
        weff = wide && (f != 3'd2) && (f != 3'd3);
        s    = '0;
        case (f)
            3'd0: return 65'd0;
            3'd1: begin
                if (weff) return {1'b0, a} + {1'b0, b} + {64'd0, ci};
                n = {1'b0, a[31:0]} + {1'b0, b[31:0]} + {32'd0, ci};
                return {n[32], 32'd0, n[31:0]};
            end
            3'd2, 3'd3: begin
                n = alu32(f, dir, bite, a[31:0], b[31:0], ci);
                return {33'd0, n[31:0]};
            end
            3'd4: s = a & b;
            3'd5: s = a | b;
            3'd6: s = ~a;
            default: s = a ^ b;
        endcase
        if (!weff) s[63:32] = '0;
        return {1'b0, s};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound of 20 cycles expired, required the event within it", name);
    endtask

    // Reference model: phase 0 idle, 1 low pass, 2 high pass, 3 result offered.
    int          ph = 0;
    logic        minit = 1'b0;
    logic [2:0]  mf;
    logic [1:0]  mdir;
    logic [4:0]  mbite;
    logic        mci, mweff, lo_carry, exp_co;
    logic [63:0] ma, mb, exp_s;
    logic [32:0] lo_sum;

    always @(negedge clk) begin
        if (!rst_n) begin
            ph    = 0;
            minit = 1'b0;
            chk("reset_outputs", {cmd_ready, busy, res_valid, res_co, res_s, alu_a, alu_b,
                                  alu_ci, alu_f, alu_dir, alu_bite}, '0);
        end else begin
            chk("cmd_ready", cmd_ready, (ph == 0) && minit);
            chk("busy", busy, ph != 0);
            chk("res_valid", res_valid, ph == 3);
            if (ph == 3) chk("result", {res_co, res_s}, {exp_co, exp_s});
            if (ph == 1)
                chk("alu_lo", {alu_a, alu_b, alu_ci, alu_f, alu_dir, alu_bite},
                    {ma[31:0], mb[31:0], mci, mf, mdir, mbite});
            else if (ph == 2)
                chk("alu_hi", {alu_a, alu_b, alu_ci, alu_f, alu_dir, alu_bite},
                    {ma[63:32], mb[63:32], (mf == 3'd1) && lo_carry, mf, mdir, mbite});
            else
                chk("alu_idle", {alu_a, alu_b, alu_ci, alu_f, alu_dir, alu_bite}, '0);
            case (ph)
                0: if (cmd_valid && minit) begin
                    mf    = cmd_f;
                    mdir  = cmd_dir;
                    mbite = cmd_bite;
                    mci   = cmd_ci;
                    ma    = cmd_a;
                    mb    = cmd_b;
                    mweff = cmd_wide && (cmd_f != 3'd2) && (cmd_f != 3'd3);
                    {exp_co, exp_s} = ref_result(cmd_f, cmd_dir, cmd_bite, cmd_ci, cmd_wide,
                                                 cmd_a, cmd_b);
                    lo_sum   = {1'b0, cmd_a[31:0]} + {1'b0, cmd_b[31:0]} + {32'd0, cmd_ci};
                    lo_carry = lo_sum[32];
                    ph = 1;
                end
                1: ph = mweff ? 2 : 3;
                2: ph = 3;
                default: if (res_ready) ph = 0;
            endcase
            minit = 1'b1;
        end
    end

    task automatic run_cmd(input logic [2:0] f, input logic [1:0] dir, input logic [4:0] bite,
                           input logic ci, input logic wide, input logic [63:0] a,
                           input logic [63:0] b, input int hold, input bit poke,
                           output int lat, output logic [63:0] s, output logic co,
                           output logic hi_ci);
        bit got;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_f = f; cmd_dir = dir; cmd_bite = bite; cmd_ci = ci; cmd_wide = wide;
        cmd_a = a; cmd_b = b;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        if (!got) fail_timeout("handshake_timeout");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a = {$urandom, $urandom};
        cmd_b = {$urandom, $urandom};
        cmd_f = 3'($urandom);
        lat = 0; hi_ci = 1'b0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 2) hi_ci = alu_ci;
            if (res_valid) begin got = 1'b1; break; end
        end
        if (!got) fail_timeout("result_timeout");
        s  = res_s;
        co = res_co;
        if (poke) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1;
            cmd_wide  = 1'b0;
        end
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        res_ready = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic reset_during_hi();
        bit got;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_f = 3'd1; cmd_wide = 1'b1; cmd_ci = 1'b1;
        cmd_a = 64'h1234_5678_9ABC_DEF0; cmd_b = 64'h1111_1111_7777_7777;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; break; end
        end
        if (!got) fail_timeout("t6_handshake_timeout");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_in_hi_alu_a", alu_a, 32'h1234_5678);
        rst_n = 1'b0;
        #1;
        chk("t6_zero_outputs", {cmd_ready, busy, res_valid, res_co, res_s, alu_a, alu_b,
                                alu_ci, alu_f, alu_dir, alu_bite}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_ready_after_release", cmd_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_result", res_valid, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [63:0] s;
        logic        co, hi_ci;
        logic [2:0]  rf;
        logic [63:0] ra, rb;

        rst_n = 1'b1;
        cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_f = '0; cmd_dir = '0; cmd_bite = '0; cmd_ci = 1'b0; cmd_wide = 1'b0;
        cmd_a = '0; cmd_b = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("model_pin_wide_add", ref_result(3'd1, 2'd0, 5'd0, 1'b1, 1'b1,
                                             64'hFFFF_FFFF_FFFF_FFFF, 64'd0),
            {1'b1, 64'd0});
        chk("model_pin_narrow_not", ref_result(3'd6, 2'd0, 5'd0, 1'b0, 1'b0,
                                               64'h0123_4567_89AB_CDEF, 64'd0),
            {33'd0, 32'h7654_3210});

        run_cmd(3'd1, 2'd0, 5'd0, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, 0, 1'b0, lat, s, co, hi_ci);
        chk("t1_latency", lat, 2);
        chk("t1_result", {co, s}, {1'b1, 64'h0});

        run_cmd(3'd1, 2'd0, 5'd0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, 1'b0,
                lat, s, co, hi_ci);
        chk("t2_latency", lat, 3);
        chk("t2_hi_ci", hi_ci, 1'b1);
        chk("t2_result", {co, s}, {1'b0, 64'h1_0000_0000});

        run_cmd(3'd7, 2'd0, 5'd0, 1'b0, 1'b1, 64'hFFFF_0000_1234_5678, 64'h0F0F_0F0F_0F0F_0F0F,
                1, 1'b0, lat, s, co, hi_ci);
        chk("t3_latency", lat, 3);
        chk("t3_result", {co, s}, {1'b0, 64'hF0F0_0F0F_1D3B_5977});

        run_cmd(3'd2, 2'd0, 5'd4, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_00F1, 64'd0, 0, 1'b0,
                lat, s, co, hi_ci);
        chk("t4_latency", lat, 2);
        chk("t4_result", {co, s}, {1'b0, 64'h0000_0000_0000_0F10});

        run_cmd(3'd5, 2'd0, 5'd0, 1'b0, 1'b0, 64'h00FF_0000, 64'h0000_00F0, 5, 1'b1,
                lat, s, co, hi_ci);
        chk("t5_result", {co, s}, {1'b0, 64'h0000_0000_00FF_00F0});

        reset_during_hi();

        for (int i = 0; i < 150; i++) begin
            rf = 3'($urandom);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            if ($urandom_range(0, 3) == 0) rb[31:0] = 32'hFFFF_FFFF;
            run_cmd(rf, 2'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), ra, rb,
                    $urandom_range(0, 3), 1'($urandom), lat, s, co, hi_ci);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
